// File: rtl/lsu.sv
// lsu: rv32i load/store unit, one handshaked word-bus access per request.
// Decodes width/alignment up front; reports misaligned, illegal and timeout.
module lsu #(
  parameter int ADDR_W  = 30,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              is_store,
  input  logic [2:0]        funct3,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  input  logic [4:0]        rd,
  output logic              busy,
  output logic              done,
  output logic [1:0]        err,
  output logic              wb_en,
  output logic [4:0]        wb_rd,
  output logic [31:0]       wb_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE
  } state_t;

  state_t        state;
  logic [2:0]    f3_q;
  logic [1:0]    off_q;
  logic          st_q;
  logic [4:0]    rd_q;
  logic [CW-1:0] cnt;

  logic          illegal;
  logic          misal;
  logic [3:0]    be;
  logic [31:0]   wd;
  logic [31:0]   lane;
  logic [31:0]   ld;

  always_comb begin
    if (is_store) illegal = funct3[2] || (funct3[1:0] == 2'b11);
    else illegal = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
    misal = ((funct3[1:0] == 2'b01) && addr[0]) ||
            ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    be = 4'b1111;
    wd = wdata;
    unique case (funct3[1:0])
      2'b00: begin
        be = 4'b0001 << addr[1:0];
        wd = {4{wdata[7:0]}};
      end
      2'b01: begin
        be = 4'b0011 << addr[1:0];
        wd = {2{wdata[15:0]}};
      end
      default: begin
        be = 4'b1111;
        wd = wdata;
      end
    endcase
  end

  // shift the addressed lane down to bit 0, then extend by width/sign
  always_comb begin
    lane = mem_rdata >> {off_q, 3'b000};
    ld = lane;
    unique case (1'b1)
      f3_q == 3'b000: ld = {{24{lane[7]}}, lane[7:0]};
      f3_q == 3'b001: ld = {{16{lane[15]}}, lane[15:0]};
      f3_q == 3'b100: ld = {24'b0, lane[7:0]};
      f3_q == 3'b101: ld = {16'b0, lane[15:0]};
      default:        ld = lane;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      f3_q      <= '0;
      off_q     <= '0;
      st_q      <= 1'b0;
      rd_q      <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= '0;
      wb_en     <= 1'b0;
      wb_rd     <= '0;
      wb_data   <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
    end else begin
      done    <= 1'b0;
      err     <= '0;
      wb_en   <= 1'b0;
      wb_rd   <= '0;
      wb_data <= '0;
      unique case (state)
        IDLE: begin
          if (start) begin
            f3_q  <= funct3;
            off_q <= addr[1:0];
            st_q  <= is_store;
            rd_q  <= rd;
            busy  <= 1'b1;
            if (illegal || misal) begin
              state <= DONE;
              done  <= 1'b1;
              wb_rd <= rd;
              err   <= illegal ? 2'b10 : 2'b01;
            end else begin
              state     <= REQ;
              cnt       <= '0;
              mem_req   <= 1'b1;
              mem_we    <= is_store;
              mem_addr  <= addr[ADDR_W+1:2];
              mem_be    <= be;
              mem_wdata <= wd;
            end
          end
        end
        REQ: begin
          if (mem_ack || (cnt == CW'(TIMEOUT - 1))) begin
            state     <= DONE;
            done      <= 1'b1;
            wb_rd     <= rd_q;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
            if (mem_ack) begin
              wb_en   <= !st_q && (rd_q != 5'd0);
              wb_data <= st_q ? 32'h0 : ld;
            end else begin
              err <= 2'b11;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
